// File: rtl/cc_neuron_sequencer_pkg.sv
// Shared definitions for the neuron sequencer: FSM encodings, input count
// and the default data width.
package cc_neuron_sequencer_pkg;

    localparam int DEFAULT_DATAWIDTH = 8;
    localparam int NUM_INPUTS        = 4;
    localparam int IDX_WIDTH         = $clog2(NUM_INPUTS);

    // Index of the last term; MAC leaves for CMP after processing it.
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_INPUTS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_CMP  = 2'd2,
        ST_DONE = 2'd3
    } seqState_t;

endpackage

// File: rtl/cc_neuron_sequencer_datapath.sv
// Arithmetic for the neuron sequencer: one shared multiplier, the
// accumulator adder and the threshold comparator. Purely combinational;
// the accumulator register itself lives in the top level.

// Unsigned multiplier whose product is truncated to the operand width.
module cc_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] product
);
    // Result is sized to WIDTH, so the upper product bits are discarded (mod 2^WIDTH).
    assign product = a * b;
endmodule

module cc_neuron_sequencer_datapath
    import cc_neuron_sequencer_pkg::*;
#(
    parameter int NUMBER_DATAWIDTH = DEFAULT_DATAWIDTH
) (
    input  logic [IDX_WIDTH-1:0]                         idx,
    input  logic [NUM_INPUTS-1:0][NUMBER_DATAWIDTH-1:0]  xVec,
    input  logic [NUM_INPUTS-1:0][NUMBER_DATAWIDTH-1:0]  wVec,
    input  logic [NUMBER_DATAWIDTH-1:0]                  acc,
    input  logic [NUMBER_DATAWIDTH-1:0]                  threshold,
    output logic [NUMBER_DATAWIDTH-1:0]                  accSum,
    output logic                                         geFlag
);
    logic [NUMBER_DATAWIDTH-1:0] xSel;
    logic [NUMBER_DATAWIDTH-1:0] wSel;
    logic [NUMBER_DATAWIDTH-1:0] product;

    // Operand mux: only the term selected by idx reaches the multiplier.
    always_comb begin
        xSel = xVec[idx];
        wSel = wVec[idx];
    end

    cc_multiplier #(
        .WIDTH (NUMBER_DATAWIDTH)
    ) uMult (
        .a       (xSel),
        .b       (wSel),
        .product (product)
    );

    // Wrapping accumulate and unsigned threshold compare.
    always_comb begin
        accSum = acc + product;
        geFlag = (acc >= threshold);
    end

endmodule

// File: rtl/cc_neuron_sequencer.sv
// Four-input neuron sequencer: latches threshold/operands/weights on start,
// accumulates one x*w term per cycle, compares against the threshold and
// pulses done with the registered decision.
module cc_neuron_sequencer
    import cc_neuron_sequencer_pkg::*;
#(
    parameter int NUMBER_DATAWIDTH = DEFAULT_DATAWIDTH
) (
    input  logic                        CC_NEURON_SEQUENCER_CLOCK_50,
    input  logic                        CC_NEURON_SEQUENCER_RESET_InLow,
    input  logic                        CC_NEURON_SEQUENCER_start_In,
    input  logic [NUMBER_DATAWIDTH-1:0] CC_NEURON_SEQUENCER_t0_InBUS,
    input  logic [NUMBER_DATAWIDTH-1:0] CC_NEURON_SEQUENCER_x0_InBUS,
    input  logic [NUMBER_DATAWIDTH-1:0] CC_NEURON_SEQUENCER_x1_InBUS,
    input  logic [NUMBER_DATAWIDTH-1:0] CC_NEURON_SEQUENCER_x2_InBUS,
    input  logic [NUMBER_DATAWIDTH-1:0] CC_NEURON_SEQUENCER_x3_InBUS,
    input  logic [NUMBER_DATAWIDTH-1:0] CC_NEURON_SEQUENCER_w0_InBUS,
    input  logic [NUMBER_DATAWIDTH-1:0] CC_NEURON_SEQUENCER_w1_InBUS,
    input  logic [NUMBER_DATAWIDTH-1:0] CC_NEURON_SEQUENCER_w2_InBUS,
    input  logic [NUMBER_DATAWIDTH-1:0] CC_NEURON_SEQUENCER_w3_InBUS,
    output logic                        CC_NEURON_SEQUENCER_busy_Out,
    output logic                        CC_NEURON_SEQUENCER_done_Out,
    output logic                        CC_NEURON_SEQUENCER_y0_Out
);
    seqState_t                                   stateReg, stateNext;
    logic [NUMBER_DATAWIDTH-1:0]                 accReg;
    logic [IDX_WIDTH-1:0]                        idxReg;
    logic [NUMBER_DATAWIDTH-1:0]                 t0Reg;
    logic [NUM_INPUTS-1:0][NUMBER_DATAWIDTH-1:0] xVecReg;
    logic [NUM_INPUTS-1:0][NUMBER_DATAWIDTH-1:0] wVecReg;
    logic [NUM_INPUTS-1:0][NUMBER_DATAWIDTH-1:0] xInVec;
    logic [NUM_INPUTS-1:0][NUMBER_DATAWIDTH-1:0] wInVec;
    logic                                        y0Reg;
    logic                                        latchEn;
    logic                                        macEn;
    logic                                        cmpEn;
    logic [NUMBER_DATAWIDTH-1:0]                 accSum;
    logic                                        geFlag;

    // Gather the individual operand ports into indexable vectors.
    always_comb begin
        xInVec = {CC_NEURON_SEQUENCER_x3_InBUS, CC_NEURON_SEQUENCER_x2_InBUS,
                  CC_NEURON_SEQUENCER_x1_InBUS, CC_NEURON_SEQUENCER_x0_InBUS};
        wInVec = {CC_NEURON_SEQUENCER_w3_InBUS, CC_NEURON_SEQUENCER_w2_InBUS,
                  CC_NEURON_SEQUENCER_w1_InBUS, CC_NEURON_SEQUENCER_w0_InBUS};
    end

    // FSM state register.
    always_ff @(posedge CC_NEURON_SEQUENCER_CLOCK_50 or negedge CC_NEURON_SEQUENCER_RESET_InLow) begin
        if (!CC_NEURON_SEQUENCER_RESET_InLow) begin
            stateReg <= ST_IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Next-state logic and per-state strobes; start is only looked at in IDLE.
    always_comb begin
        stateNext                    = stateReg;
        latchEn                      = 1'b0;
        macEn                        = 1'b0;
        cmpEn                        = 1'b0;
        CC_NEURON_SEQUENCER_busy_Out = (stateReg != ST_IDLE);
        CC_NEURON_SEQUENCER_done_Out = 1'b0;
        case (stateReg)
            ST_IDLE: begin
                if (CC_NEURON_SEQUENCER_start_In) begin
                    latchEn   = 1'b1;
                    stateNext = ST_MAC;
                end
            end
            ST_MAC: begin
                macEn = 1'b1;
                if (idxReg == LAST_IDX) begin
                    stateNext = ST_CMP;
                end
            end
            ST_CMP: begin
                cmpEn     = 1'b1;
                stateNext = ST_DONE;
            end
            ST_DONE: begin
                CC_NEURON_SEQUENCER_done_Out = 1'b1;
                stateNext                    = ST_IDLE;
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    // Operand capture at the accepting edge; held stable while busy.
    always_ff @(posedge CC_NEURON_SEQUENCER_CLOCK_50 or negedge CC_NEURON_SEQUENCER_RESET_InLow) begin
        if (!CC_NEURON_SEQUENCER_RESET_InLow) begin
            t0Reg   <= '0;
            xVecReg <= '0;
            wVecReg <= '0;
        end else if (latchEn) begin
            t0Reg   <= CC_NEURON_SEQUENCER_t0_InBUS;
            xVecReg <= xInVec;
            wVecReg <= wInVec;
        end
    end

    // Accumulator and term index: cleared on accept, advanced once per MAC cycle.
    always_ff @(posedge CC_NEURON_SEQUENCER_CLOCK_50 or negedge CC_NEURON_SEQUENCER_RESET_InLow) begin
        if (!CC_NEURON_SEQUENCER_RESET_InLow) begin
            accReg <= '0;
            idxReg <= '0;
        end else if (latchEn) begin
            accReg <= '0;
            idxReg <= '0;
        end else if (macEn) begin
            accReg <= accSum;
            idxReg <= idxReg + 1'b1;
        end
    end

    // Decision register: updated only on the compare edge, held otherwise.
    always_ff @(posedge CC_NEURON_SEQUENCER_CLOCK_50 or negedge CC_NEURON_SEQUENCER_RESET_InLow) begin
        if (!CC_NEURON_SEQUENCER_RESET_InLow) begin
            y0Reg <= 1'b0;
        end else if (cmpEn) begin
            y0Reg <= geFlag;
        end
    end

    assign CC_NEURON_SEQUENCER_y0_Out = y0Reg;

    cc_neuron_sequencer_datapath #(
        .NUMBER_DATAWIDTH (NUMBER_DATAWIDTH)
    ) uDatapath (
        .idx       (idxReg),
        .xVec      (xVecReg),
        .wVec      (wVecReg),
        .acc       (accReg),
        .threshold (t0Reg),
        .accSum    (accSum),
        .geFlag    (geFlag)
    );

endmodule

// File: tb/tb_cc_neuron_sequencer.sv
// Directed bench for cc_neuron_sequencer: a table of operand sets with
// hand-computed decisions, plus sequences for start-while-busy,
// back-to-back starts and mid-operation reset.
module tb_cc_neuron_sequencer;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rstN;
    logic         start;
    logic [W-1:0] t0, x0, x1, x2, x3, w0, w1, w2, w3;
    logic         busy, done, y0;

    typedef struct {
        logic [3:0][W-1:0] x;
        logic [3:0][W-1:0] w;
        logic [W-1:0]      t0;
        logic              expY;
    } vec_t;

    int   nChecks = 0;
    int   nMiss   = 0;
    vec_t tbl [8];
    vec_t vBad;
    logic prevY;
    int   doneCnt;

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    cc_neuron_sequencer #(.NUMBER_DATAWIDTH(W)) dut (
        .CC_NEURON_SEQUENCER_CLOCK_50    (clk),
        .CC_NEURON_SEQUENCER_RESET_InLow (rstN),
        .CC_NEURON_SEQUENCER_start_In    (start),
        .CC_NEURON_SEQUENCER_t0_InBUS    (t0),
        .CC_NEURON_SEQUENCER_x0_InBUS    (x0),
        .CC_NEURON_SEQUENCER_x1_InBUS    (x1),
        .CC_NEURON_SEQUENCER_x2_InBUS    (x2),
        .CC_NEURON_SEQUENCER_x3_InBUS    (x3),
        .CC_NEURON_SEQUENCER_w0_InBUS    (w0),
        .CC_NEURON_SEQUENCER_w1_InBUS    (w1),
        .CC_NEURON_SEQUENCER_w2_InBUS    (w2),
        .CC_NEURON_SEQUENCER_w3_InBUS    (w3),
        .CC_NEURON_SEQUENCER_busy_Out    (busy),
        .CC_NEURON_SEQUENCER_done_Out    (done),
        .CC_NEURON_SEQUENCER_y0_Out      (y0)
    );

    function automatic vec_t mk(input logic [W-1:0] a0, a1, a2, a3,
                                input logic [W-1:0] b0, b1, b2, b3,
                                input logic [W-1:0] t, input logic e);
        vec_t v;
        v.x    = {a3, a2, a1, a0};
        v.w    = {b3, b2, b1, b0};
        v.t0   = t;
        v.expY = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nMiss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance past the next rising edge; all sampling and driving happens 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        x0 = v.x[0]; x1 = v.x[1]; x2 = v.x[2]; x3 = v.x[3];
        w0 = v.w[0]; w1 = v.w[1]; w2 = v.w[2]; w3 = v.w[3];
        t0 = v.t0;
    endtask

    task automatic scramble();
        x0 = W'($urandom); x1 = W'($urandom); x2 = W'($urandom); x3 = W'($urandom);
        w0 = W'($urandom); w1 = W'($urandom); w2 = W'($urandom); w3 = W'($urandom);
        t0 = W'($urandom);
    endtask

    // One evaluation with a start pulse; inputs are scrambled right after acceptance.
    task automatic runEval(input vec_t v, input logic py, input string tag);
        check($sformatf("%s idle busy", tag), busy, 0);
        drive(v);
        start = 1'b1;
        tick();                       // edge k: accept
        start = 1'b0;
        scramble();
        for (int c = 1; c <= 4; c++) begin
            tick();                   // edges k+1..k+4
            check($sformatf("%s mac%0d busy", tag, c), busy, 1);
            check($sformatf("%s mac%0d done", tag, c), done, 0);
            check($sformatf("%s mac%0d y0 hold", tag, c), y0, py);
        end
        tick();                       // edge k+5
        check($sformatf("%s done pulse", tag), done, 1);
        check($sformatf("%s y0", tag), y0, v.expY);
        check($sformatf("%s busy in done", tag), busy, 1);
        tick();                       // edge k+6
        check($sformatf("%s done drop", tag), done, 0);
        check($sformatf("%s busy drop", tag), busy, 0);
        check($sformatf("%s y0 held", tag), y0, v.expY);
        $display("vector %s: y0=%0d expected=%0d", tag, y0, v.expY);
    endtask

    initial begin
        rstN  = 1'b0;
        start = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0));

        tbl[0] = mk(1, 2, 3, 4,       1, 1, 1, 1,       10,  1'b1);
        tbl[1] = mk(1, 2, 3, 4,       1, 1, 1, 1,       11,  1'b0);
        tbl[2] = mk(15, 1, 0, 0,      17, 1, 0, 0,      1,   1'b0);  // 255+1 wraps to 0
        tbl[3] = mk(16, 1, 0, 0,      16, 1, 0, 0,      1,   1'b1);  // 256 truncates to 0
        tbl[4] = mk(0, 0, 0, 0,       0, 0, 0, 0,       0,   1'b1);  // equal at zero
        tbl[5] = mk(255, 255, 255, 255, 255, 255, 255, 255, 4, 1'b1); // each term 1, acc 4
        tbl[6] = mk(3, 5, 7, 9,       2, 4, 6, 8,       140, 1'b1);  // acc 140, equal
        tbl[7] = mk(200, 100, 20, 0,  2, 1, 1, 0,       9,   1'b0);  // 144+100+20 -> 8
        vBad   = mk(0, 0, 0, 0,       0, 0, 0, 0,       255, 1'b0);

        // Reset state, observed while reset is held.
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset y0", y0, 0);
        tick();
        tick();
        rstN = 1'b1;
        tick();
        check("post-reset busy", busy, 0);

        // Table-driven evaluations.
        prevY = 1'b0;
        for (int i = 0; i < 8; i++) begin
            runEval(tbl[i], prevY, $sformatf("tbl%0d", i));
            prevY = tbl[i].expY;
        end

        // Start repeated during MAC/CMP/DONE with operand change: one done, original result.
        drive(tbl[0]);
        start = 1'b1;
        tick();                        // edge k
        drive(vBad);
        doneCnt = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (done) doneCnt++;
            if (c == 5) check("ignore done at k+5", done, 1);
            if (c == 6) start = 1'b0;
        end
        check("ignore done count", doneCnt, 1);
        check("ignore y0", y0, 1);
        check("ignore busy end", busy, 0);
        $display("vector ignore-start: dones=%0d y0=%0d", doneCnt, y0);

        // start held high: back-to-back evaluations with fresh latch.
        drive(tbl[1]);
        start = 1'b1;
        tick();                        // edge k
        for (int c = 1; c <= 13; c++) begin
            tick();
            if (c == 4) check("b2b y0 hold", y0, 1);
            if (c == 5) begin
                check("b2b first done", done, 1);
                check("b2b first y0", y0, 0);
            end
            if (c == 6) begin
                check("b2b idle gap", busy, 0);
                drive(tbl[6]);
            end
            if (c == 7) begin
                check("b2b reaccept busy", busy, 1);
                start = 1'b0;
            end
            if (c == 11) check("b2b second early done", done, 0);
            if (c == 12) begin
                check("b2b second done", done, 1);
                check("b2b second y0", y0, 1);
            end
            if (c == 13) check("b2b final busy", busy, 0);
        end
        $display("vector back-to-back: y0=%0d", y0);

        // Mid-operation reset: immediate clear, no done, clean restart.
        drive(tbl[0]);
        start = 1'b1;
        tick();                        // edge k
        start = 1'b0;
        tick();
        tick();                        // edge k+2
        rstN = 1'b0;
        #1;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort y0", y0, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("abort no done", done, 0);
        end
        rstN = 1'b1;
        tick();
        check("abort idle", busy, 0);
        runEval(tbl[0], 1'b0, "after-reset");

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nMiss);
        $finish;
    end

endmodule
